sipo_demux_1_8: RTL and testbench
=================================

Name: sipo_demux_1_8

Overview:
- Serial-to-parallel collector, the receive-side counterpart of the 8:1 bit mux.
- A 3-bit write index demultiplexes each accepted serial bit into one slot of an assembly register.
- When WIDTH bits have been collected, the word moves to a one-entry output buffer with a valid/ready handshake.
- Sits between a bit-serial link and word-wide datapath logic.

Parameters:
- WIDTH, 8, bits per word (power of 2, at least 2).
- IDX_W, $clog2(WIDTH), width of the slot index.
- MSB_FIRST, 0, 0: first bit lands in slot 0; 1: first bit lands in slot WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts bit_in this cycle.
- clear  input  1  synchronous flush of the partial word.
- slot_idx  output  IDX_W  slot the next accepted bit is written to.
- word_out  output  WIDTH  assembled word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer takes word_out this cycle.
- overflow_cnt  output  8  saturating count of cycles where bit_valid=1 and bit_ready=0.

Behaviour:
- Reset (rst_n=0, async): asm=0, idx=0, word_out=0, word_valid=0, overflow_cnt=0.
- Reset state at outputs: bit_ready=1, slot_idx=0 (or WIDTH-1 if MSB_FIRST).
- Accept: bit_valid && bit_ready.
- slot = idx when MSB_FIRST=0, otherwise WIDTH-1-idx; slot_idx = slot.
- On accept: asm[slot] <= bit_in; idx <= idx+1, wrapping to 0 after WIDTH-1.
- Completion: an accept while idx==WIDTH-1.
  - Next cycle: word_out = asm with the final bit merged, word_valid=1, asm cleared to 0, idx=0.
  - Latency: last bit accepted in cycle N -> word_valid=1 in N+1.
- Consume: word_valid && word_ready -> word_valid <= 0, unless a completion occurs in the same cycle.
- Consume and completion in the same cycle: word_out reloads with the new word and word_valid stays 1, giving full throughput.
- bit_ready = !clear && !(idx==WIDTH-1 && word_valid && !word_ready).
  - Bits for the next word keep flowing while a word is held.
  - Only the completing bit stalls on a full output buffer.
  - bit_ready is combinational from word_ready.
- clear=1: asm<=0, idx<=0, no bit accepted that cycle.
  - Output buffer and word_valid are unaffected; a held word survives clear.
  - clear with word_ready=1 still completes the consume.
- Stall is lossless: bit_in is never sampled while bit_ready=0.
- overflow_cnt increments by 1 each stall cycle with bit_valid=1 and saturates at 255; cleared only by reset.
- word_out is stable while word_valid && !word_ready.
- Reset mid-word: partial word discarded, held word discarded, all state as at reset.
- Mid-word states: the idx counter implies two states.
  - EMPTY: idx==0.
  - FILLING: idx!=0.
  - No further FSM.

Decomposition:
- Shared package: default WIDTH and MSB_FIRST constant, and an index-width function used by the block and the matching mux-side serializer.
- One natural sub-module, out_buf_1: a one-entry valid/ready holding register.
  - Inputs: load, data, ready.
  - Outputs: data_q, valid_q.
  - Generic, reusable on the serializer side.
- Index counter and demux write stay in the top module.

Test Plan:
- After reset, feed 1,0,1,1,0,0,1,0 with bit_valid=1 and word_ready=1 -> word_out=8'h4D, one-cycle word_valid pulse in the cycle after the 8th bit.
- Same stream with MSB_FIRST=1 -> word_out=8'hB2.
- word_ready=0, stream 16 bits of 8'hFF then 8'h00 -> first word held at FF.
  - bit_ready=0 only at the 16th bit, overflow_cnt counts the stall cycles.
  - Raising word_ready -> FF consumed, then 00 presented one cycle later.
- Continuous 32-bit stream with word_ready=1 -> four words, no bit_ready deassertion, back-to-back completion/consume reloads.
- Three bits accepted, then clear=1 for one cycle while word_valid=1 -> slot_idx returns to 0, held word unchanged, next 8 bits form a clean word.
- Assert rst_n=0 asynchronously mid-word with word_valid=1 -> word_valid, slot_idx and overflow_cnt go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sipo_demux_1_8_pkg.sv
// Shared defaults and helpers for the bit-serial mux/demux pair.
// Both the serializer and the collector use idx_width() so their slot counters agree.
package sipo_demux_1_8_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam bit DEF_MSB_FIRST = 1'b0;

  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_demux_1_8_out_buf.sv
// One-entry valid/ready holding register: load wins over a same-cycle consume,
// so a new word can replace the departing one with no bubble.
module out_buf_1 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic [W-1:0] data_q,
  output logic         valid_q
);

  logic [W-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= data;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data_q  = r_data;
  assign valid_q = r_valid;

endmodule

// File: rtl/sipo_demux_1_8.sv
// Serial-to-parallel collector: demuxes accepted bits into an assembly register and
// hands full words to a one-entry output buffer; only the completing bit stalls on a full buffer.
module sipo_demux_1_8 import sipo_demux_1_8_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IDX_W     = idx_width(WIDTH),
  parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clear,
  output logic [IDX_W-1:0] slot_idx,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [7:0]       overflow_cnt
);

  logic [WIDTH-1:0] r_asm;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_ovf;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_word_q;
  logic [IDX_W-1:0] w_slot;
  logic             w_last;
  logic             w_accept;
  logic             w_complete;
  logic             w_valid_q;

  assign w_slot     = MSB_FIRST ? (IDX_W'(WIDTH - 1) - r_idx) : r_idx;
  assign w_last     = (r_idx == IDX_W'(WIDTH - 1));
  assign bit_ready  = !clear && !(w_last && w_valid_q && !word_ready);
  assign w_accept   = bit_valid && bit_ready;
  assign w_complete = w_accept && w_last;

  // The completing bit never lands in r_asm; it is merged straight into the outgoing word.
  always_comb begin
    w_merged         = r_asm;
    w_merged[w_slot] = bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (clear) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_asm <= '0;
        r_idx <= '0;
      end else begin
        r_asm[w_slot] <= bit_in;
        r_idx         <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (bit_valid && !bit_ready && (r_ovf != 8'hFF)) begin
      r_ovf <= r_ovf + 8'd1;
    end
  end

  out_buf_1 #(.W(WIDTH)) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_complete),
    .data    (w_merged),
    .ready   (word_ready),
    .data_q  (w_word_q),
    .valid_q (w_valid_q)
  );

  assign slot_idx     = w_slot;
  assign word_out     = w_word_q;
  assign word_valid   = w_valid_q;
  assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_sipo_demux_1_8.sv
// Bench for sipo_demux_1_8: LSB-first and MSB-first instances share one stimulus stream
// and are compared against a word-level model (bit list per word, one held output word).
module tb_sipo_demux_1_8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0, clear = 1'b0, word_ready = 1'b0;

  logic       l_rdy, m_rdy, l_val, m_val;
  logic [2:0] l_slot, m_slot;
  logic [7:0] l_word, m_word, l_ovf, m_ovf_o;

  always #5 clk = ~clk;

  sipo_demux_1_8 #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(l_rdy),
    .clear(clear), .slot_idx(l_slot), .word_out(l_word), .word_valid(l_val),
    .word_ready(word_ready), .overflow_cnt(l_ovf));

  sipo_demux_1_8 #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(m_rdy),
    .clear(clear), .slot_idx(m_slot), .word_out(m_word), .word_valid(m_val),
    .word_ready(word_ready), .overflow_cnt(m_ovf_o));

  int nvec = 0;
  int nerr = 0;

  // Model: bits of the word in arrival order, plus the single held word.
  bit       m_bits[8];
  int       m_cnt;
  bit [7:0] m_word_lo, m_word_hi;
  bit       m_valid;
  int       m_ovf;
  bit       m_exp_ready;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_word_lo = 0; m_word_hi = 0; m_valid = 0; m_ovf = 0;
    for (int k = 0; k < 8; k++) m_bits[k] = 0;
  endtask

  task automatic model_check();
    m_exp_ready = !clear && !((m_cnt == 7) && m_valid && !word_ready);
    chk("bit_ready_lsb", int'(l_rdy), int'(m_exp_ready));
    chk("bit_ready_msb", int'(m_rdy), int'(m_exp_ready));
    chk("slot_lsb", int'(l_slot), m_cnt);
    chk("slot_msb", int'(m_slot), 7 - m_cnt);
    chk("valid_lsb", int'(l_val), int'(m_valid));
    chk("valid_msb", int'(m_val), int'(m_valid));
    chk("word_lsb", int'(l_word), int'(m_word_lo));
    chk("word_msb", int'(m_word), int'(m_word_hi));
    chk("ovf_lsb", int'(l_ovf), m_ovf);
    chk("ovf_msb", int'(m_ovf_o), m_ovf);
  endtask

  task automatic model_update();
    bit done;
    done = 0;
    if (bit_valid && !m_exp_ready && m_ovf < 255) m_ovf++;
    if (clear) begin
      m_cnt = 0;
    end else if (bit_valid && m_exp_ready) begin
      m_bits[m_cnt] = bit_in;
      m_cnt++;
      if (m_cnt == 8) begin
        for (int k = 0; k < 8; k++) begin
          m_word_lo[k]     = m_bits[k];
          m_word_hi[7 - k] = m_bits[k];
        end
        m_cnt = 0;
        done  = 1;
      end
    end
    if (done) m_valid = 1;
    else if (m_valid && word_ready) m_valid = 0;
  endtask

  task automatic drive(input logic bi, input logic bv, input logic cl, input logic wr);
    bit_in = bi; bit_valid = bv; clear = cl; word_ready = wr;
    #3;
  endtask

  task automatic finish_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic bi, input logic bv, input logic cl, input logic wr);
    drive(bi, bv, cl, wr);
    model_check();
    finish_cycle();
  endtask

  task automatic do_reset();
    bit_in = 0; bit_valid = 0; clear = 0; word_ready = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       bi, bv, cl, wr;
    logic       exp_rdy, exp_val;
    logic [7:0] exp_lo, exp_hi;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit [7:0] pat;
    bit [7:0] held;
    int words, stalls;

    // Stream 1,0,1,1,0,0,1,0 -> 4D LSB-first, B2 MSB-first, one-cycle valid pulse.
    tbl[0] = '{1, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[1] = '{0, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[2] = '{1, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[3] = '{1, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[4] = '{0, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[5] = '{0, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[6] = '{1, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[7] = '{0, 1, 0, 1, 1, 0, 8'h00, 8'h00};
    tbl[8] = '{0, 0, 0, 1, 1, 1, 8'h4D, 8'hB2};
    tbl[9] = '{0, 0, 0, 1, 1, 0, 8'h4D, 8'hB2};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].bi, tbl[i].bv, tbl[i].cl, tbl[i].wr);
      chk("tbl_ready", int'(l_rdy), int'(tbl[i].exp_rdy));
      chk("tbl_valid", int'(l_val), int'(tbl[i].exp_val));
      chk("tbl_word_lsb", int'(l_word), int'(tbl[i].exp_lo));
      chk("tbl_word_msb", int'(m_word), int'(tbl[i].exp_hi));
      model_check();
      finish_cycle();
    end

    // Backpressure: FF held, 16th bit stalls three cycles, then consume+complete reload.
    do_reset();
    for (int i = 0; i < 15; i++) step((i < 8) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_stall_ready", int'(l_rdy), 0);
    chk("bp_ovf", int'(l_ovf), 3);
    chk("bp_held_word", int'(l_word), 8'hFF);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("bp_reload_word", int'(l_word), 8'h00);
    chk("bp_reload_valid", int'(l_val), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_drained", int'(l_val), 0);

    // Continuous 32-bit stream with the consumer always ready.
    do_reset();
    words = 0; stalls = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      if (l_val) words++;
      if (!l_rdy) stalls++;
    end
    chk("cont_words", words, 4);
    chk("cont_stalls", stalls, 0);

    // Clear mid-word while a word is held.
    do_reset();
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) step(pat[i], 1'b1, 1'b0, 1'b0);
    held = l_word;
    chk("clr_held_before", int'(held), 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_slot", int'(l_slot), 0);
    chk("clr_held_after", int'(l_word), 8'hA5);
    chk("clr_valid_after", int'(l_val), 1);
    pat = 8'h3C;
    for (int i = 0; i < 8; i++) step(pat[i], 1'b1, 1'b0, 1'b1);
    chk("clr_clean_word", int'(l_word), 8'h3C);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) != 0));

    // Asynchronous reset mid-word with a held word and a nonzero overflow count.
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ar_pre_valid", int'(l_val), 1);
    chk("ar_pre_ovf", int'(l_ovf), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(l_val), 0);
    chk("ar_slot_lsb", int'(l_slot), 0);
    chk("ar_slot_msb", int'(m_slot), 7);
    chk("ar_ovf", int'(l_ovf), 0);
    chk("ar_word", int'(l_word), 0);
    model_reset();
    bit_valid = 0; clear = 0; word_ready = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
